// File: rtl/hex_display_arbiter_pkg.sv
// Shared types and segment tables for the HEX display arbiter.
// Segment images are active low, bit0 = a ... bit6 = g.
package hex_disp_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE_ECHO,
    ST_WRITE_MSG,
    ST_HOLD
  } state_t;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_DASH  = 7'h3F;
  localparam logic [27:0] IMG_BLANK = {4{SEG_BLANK}};

  // Non-decimal nibbles show a dash rather than a hex glyph.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // Images are {HEX3, HEX2, HEX1, HEX0}, leftmost character first.
  function automatic logic [27:0] msg_image(input logic [2:0] code);
    logic [27:0] img;
    case (code)
      3'd0:    img = IMG_BLANK;
      3'd1:    img = {7'h40, 7'h0C, 7'h06, 7'h2B};
      3'd2:    img = {7'h06, 7'h2F, 7'h2F, SEG_BLANK};
      3'd3:    img = {7'h47, 7'h40, 7'h46, SEG_BLANK};
      3'd4:    img = {4{SEG_DASH}};
      3'd5:    img = {4{7'h00}};
      default: img = {4{SEG_DASH}};
    endcase
    return img;
  endfunction

endpackage

// File: rtl/hex_display_arbiter_if.sv
// Avalon-MM write-only link between the arbiter and the HEX PIO slave.
interface hex_display_arbiter_if;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  modport master (
    output pio_address, pio_chipselect, pio_write_n, pio_writedata
  );

  modport slave (
    input pio_address, pio_chipselect, pio_write_n, pio_writedata
  );
endinterface

// File: rtl/hex_display_arbiter_sevenseg_encode.sv
// One digit: BCD nibble plus enable to an active-low 7-segment pattern.
module sevenseg_encode
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_enable,
  output logic [6:0] o_seg
);

  assign o_seg = i_enable ? bcd_to_seg(i_nibble) : SEG_BLANK;

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares the four-digit HEX PIO between keypad echo and timed status messages.
// Every display change is a single-cycle PIO write.
//
// state      | meaning
// INIT       | first cycle after reset, blank write issued
// IDLE       | waiting for a message or a pending echo image
// WRITE_ECHO | strobing the newest echo image
// WRITE_MSG  | strobing a message image, loading the hold timer
// HOLD       | message on display, timer counting down
module hex_display_arbiter
  import hex_disp_pkg::*;
#(
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  echo_valid,
  input  logic [15:0]           echo_digits,
  input  logic [3:0]            echo_mask,
  input  logic                  msg_valid,
  input  logic [2:0]            msg_code,
  output logic                  msg_ready,
  output logic                  busy,
  hex_display_arbiter_if.master pio
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_shadow_digits;
  logic [3:0]       r_shadow_mask;
  logic             r_pending;
  logic             w_pending_nxt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic             w_hold_done;
  logic             r_cs;
  logic             r_write_n;
  logic [27:0]      r_image;
  logic [15:0]      w_digits_nxt;
  logic [3:0]       w_mask_nxt;
  logic [27:0]      w_echo_img;

  // Encode the shadow as it will be after this edge, so an echo arriving in
  // the same cycle as the write decision is the one that gets written.
  assign w_digits_nxt = echo_valid ? echo_digits : r_shadow_digits;
  assign w_mask_nxt   = echo_valid ? echo_mask   : r_shadow_mask;
  assign w_hold_done  = (r_hold_cnt == '0);

  for (genvar g = 0; g < 4; g++) begin : g_digit
    sevenseg_encode u_enc (
      .i_nibble (w_digits_nxt[4*g +: 4]),
      .i_enable (w_mask_nxt[g]),
      .o_seg    (w_echo_img[7*g +: 7])
    );
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending | echo_valid;
    case (r_state)
      ST_INIT: w_state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (msg_valid)      w_state_nxt = ST_WRITE_MSG;
        else if (r_pending) w_state_nxt = ST_WRITE_ECHO;
      end
      ST_WRITE_ECHO: begin
        w_state_nxt   = ST_IDLE;
        w_pending_nxt = echo_valid;
      end
      ST_WRITE_MSG: w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (msg_valid) begin
          w_state_nxt = ST_WRITE_MSG;
        end else if (w_hold_done) begin
          w_state_nxt   = ST_IDLE;
          w_pending_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_INIT;
      r_shadow_digits <= '0;
      r_shadow_mask   <= '0;
      r_pending       <= 1'b0;
      r_hold_cnt      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      if (echo_valid) begin
        r_shadow_digits <= echo_digits;
        r_shadow_mask   <= echo_mask;
      end
      if (r_state == ST_WRITE_MSG)
        r_hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
      else if (r_state == ST_HOLD && !w_hold_done)
        r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  // Strobe registers load on the edge that enters a write state, so the
  // strobe coincides with that state; the INIT blank lands one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs      <= 1'b0;
      r_write_n <= 1'b1;
      r_image   <= '0;
    end else begin
      r_cs      <= 1'b0;
      r_write_n <= 1'b1;
      if (r_state == ST_INIT) begin
        r_cs      <= 1'b1;
        r_write_n <= 1'b0;
        r_image   <= IMG_BLANK;
      end else if (w_state_nxt == ST_WRITE_MSG) begin
        r_cs      <= 1'b1;
        r_write_n <= 1'b0;
        r_image   <= msg_image(msg_code);
      end else if (w_state_nxt == ST_WRITE_ECHO) begin
        r_cs      <= 1'b1;
        r_write_n <= 1'b0;
        r_image   <= w_echo_img;
      end
    end
  end

  assign msg_ready = (r_state == ST_IDLE) || (r_state == ST_HOLD);
  assign busy      = (r_state == ST_HOLD);

  assign pio.pio_address    = 2'b00;
  assign pio.pio_chipselect = r_cs;
  assign pio.pio_write_n    = r_write_n;
  assign pio.pio_writedata  = {4'h0, r_image};

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed and randomized checks of hex_display_arbiter against a
// character-level display model and an expected-write queue.
module tb_hex_display_arbiter;

  localparam int HOLD = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        echo_valid = 1'b0;
  logic [15:0] echo_digits = '0;
  logic [3:0]  echo_mask = '0;
  logic        msg_valid = 1'b0;
  logic [2:0]  msg_code = '0;
  logic        msg_ready;
  logic        busy;

  hex_display_arbiter_if pio_if ();

  hex_display_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .echo_valid  (echo_valid),
    .echo_digits (echo_digits),
    .echo_mask   (echo_mask),
    .msg_valid   (msg_valid),
    .msg_code    (msg_code),
    .msg_ready   (msg_ready),
    .busy        (busy),
    .pio         (pio_if.master)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          n_wr = 0;
  logic [27:0] exp_q[$];
  logic [15:0] m_digits = '0;
  logic [3:0]  m_mask = '0;

  function automatic logic [6:0] seg_of(input byte c);
    string      lit;
    logic [6:0] s;
    case (c)
      "0", "O": lit = "abcdef";
      "1":      lit = "bc";
      "2":      lit = "abdeg";
      "3":      lit = "abcdg";
      "4":      lit = "bcfg";
      "5":      lit = "acdfg";
      "6":      lit = "acdefg";
      "7":      lit = "abc";
      "8":      lit = "abcdefg";
      "9":      lit = "abcdfg";
      "P":      lit = "abefg";
      "E":      lit = "adefg";
      "n":      lit = "ceg";
      "r":      lit = "eg";
      "L":      lit = "def";
      "C":      lit = "adef";
      "-":      lit = "g";
      default:  lit = "";
    endcase
    s = 7'h7F;
    for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
    return s;
  endfunction

  function automatic logic [27:0] text_image(input string t);
    logic [27:0] img;
    img = '0;
    for (int i = 0; i < 4; i++) img[27 - 7*i -: 7] = seg_of(t[i]);
    return img;
  endfunction

  function automatic string msg_text(input int code);
    case (code)
      0:       return "    ";
      1:       return "OPEn";
      2:       return "Err ";
      3:       return "LOC ";
      4:       return "----";
      5:       return "8888";
      default: return "----";
    endcase
  endfunction

  function automatic logic [27:0] echo_image(input logic [15:0] d, input logic [3:0] m);
    string t;
    int    k;
    int    nib;
    t = "    ";
    for (int pos = 0; pos < 4; pos++) begin
      k   = 3 - pos;
      nib = int'(d[4*k +: 4]);
      if (!m[k])        t.putc(pos, " ");
      else if (nib < 10) t.putc(pos, byte'(48 + nib));
      else              t.putc(pos, "-");
    end
    return text_image(t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and score any write strobe seen there.
  task automatic tick();
    @(negedge clk);
    if (pio_if.pio_chipselect === 1'b1) begin
      n_wr++;
      chk("wr_n_with_cs", 32'(pio_if.pio_write_n), 32'd0);
      chk("wr_addr", 32'(pio_if.pio_address), 32'd0);
      chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("wr_data", pio_if.pio_writedata, {4'h0, exp_q.pop_front()});
    end else begin
      chk("idle_write_n", 32'(pio_if.pio_write_n), 32'd1);
    end
  endtask

  task automatic send_echo(input logic [15:0] d, input logic [3:0] m);
    echo_digits = d;
    echo_mask   = m;
    echo_valid  = 1'b1;
    m_digits    = d;
    m_mask      = m;
    tick();
    echo_valid  = 1'b0;
  endtask

  task automatic echo_in_idle(input logic [15:0] d, input logic [3:0] m);
    int w0;
    w0 = n_wr;
    exp_q.push_back(echo_image(d, m));
    send_echo(d, m);
    chk("echo_early", 32'(n_wr - w0), 32'd0);
    tick();
    chk("echo_latency", 32'(n_wr - w0), 32'd1);
    chk("ready_in_write", 32'(msg_ready), 32'd0);
    tick();
  endtask

  task automatic send_msg(input logic [2:0] code);
    int w0;
    int t;
    t = 0;
    while (msg_ready !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    chk("ready_wait", 32'(msg_ready), 32'd1);
    msg_code  = code;
    msg_valid = 1'b1;
    exp_q.push_back(text_image(msg_text(int'(code))));
    w0 = n_wr;
    tick();
    msg_valid = 1'b0;
    chk("msg_latency", 32'(n_wr - w0), 32'd1);
  endtask

  // Called on the message strobe cycle; counts the hold and checks the restore.
  task automatic hold_and_restore(input int n_echo);
    int w0;
    int nb;
    w0 = n_wr;
    nb = 0;
    for (int i = 0; i < n_echo; i++) begin
      send_echo(16'($urandom), 4'($urandom));
      if (busy === 1'b1) nb++;
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy === 1'b1) nb++;
      else break;
    end
    chk("busy_len", 32'(nb), 32'(HOLD));
    chk("no_write_in_hold", 32'(n_wr - w0), 32'd0);
    exp_q.push_back(echo_image(m_digits, m_mask));
    tick();
    chk("restore_latency", 32'(n_wr - w0), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [15:0] d;
    logic [3:0]  m;

    repeat (3) tick();
    chk("rst_cs", 32'(pio_if.pio_chipselect), 32'd0);
    chk("rst_write_n", 32'(pio_if.pio_write_n), 32'd1);
    chk("rst_addr", 32'(pio_if.pio_address), 32'd0);
    chk("rst_data", pio_if.pio_writedata, 32'd0);
    chk("rst_ready", 32'(msg_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    reset_n = 1'b1;
    #1;
    chk("init_ready", 32'(msg_ready), 32'd0);
    exp_q.push_back(28'hFFFFFFF);
    w0 = n_wr;
    tick();
    chk("init_write", 32'(n_wr - w0), 32'd1);
    chk("idle_ready", 32'(msg_ready), 32'd1);
    repeat (100) tick();
    chk("init_quiet", 32'(n_wr - w0), 32'd1);

    echo_in_idle(16'h1234, 4'hF);
    echo_in_idle(16'h00A9, 4'h3);

    send_msg(3'd2);
    hold_and_restore(0);

    send_msg(3'd1);
    hold_and_restore(2);

    // Preempt message 1 four cycles into its hold.
    send_msg(3'd1);
    w0 = n_wr;
    repeat (4) begin
      tick();
      chk("preempt_busy", 32'(busy), 32'd1);
    end
    send_msg(3'd3);
    hold_and_restore(0);

    // Echo and message in the same IDLE cycle.
    echo_digits = 16'h5678;
    echo_mask   = 4'hF;
    echo_valid  = 1'b1;
    m_digits    = 16'h5678;
    m_mask      = 4'hF;
    msg_code    = 3'd7;
    msg_valid   = 1'b1;
    exp_q.push_back(text_image(msg_text(7)));
    w0 = n_wr;
    tick();
    echo_valid = 1'b0;
    msg_valid  = 1'b0;
    chk("both_msg_first", 32'(n_wr - w0), 32'd1);
    hold_and_restore(0);

    // Echo arriving during an echo write forces a second write.
    w0 = n_wr;
    exp_q.push_back(echo_image(16'h0909, 4'hA));
    send_echo(16'h0909, 4'hA);
    tick();
    exp_q.push_back(echo_image(16'h4321, 4'h5));
    send_echo(16'h4321, 4'h5);
    chk("reecho_gap", 32'(n_wr - w0), 32'd1);
    tick();
    chk("reecho_count", 32'(n_wr - w0), 32'd2);
    tick();

    for (int it = 0; it < 12; it++) begin
      d = 16'($urandom);
      m = 4'($urandom);
      case ($urandom_range(0, 2))
        0: echo_in_idle(d, m);
        1: begin
          send_msg(3'($urandom_range(0, 7)));
          hold_and_restore(int'($urandom_range(0, 3)));
        end
        default: begin
          echo_digits = d;
          echo_mask   = m;
          echo_valid  = 1'b1;
          m_digits    = d;
          m_mask      = m;
          msg_code    = 3'($urandom_range(0, 7));
          msg_valid   = 1'b1;
          exp_q.push_back(text_image(msg_text(int'(msg_code))));
          w0 = n_wr;
          tick();
          echo_valid = 1'b0;
          msg_valid  = 1'b0;
          chk("rand_both_msg", 32'(n_wr - w0), 32'd1);
          hold_and_restore(0);
        end
      endcase
    end

    // Reset while the message strobe is on the bus.
    send_msg(3'd2);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cs", 32'(pio_if.pio_chipselect), 32'd0);
    chk("rst_mid_write_n", 32'(pio_if.pio_write_n), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    m_digits = '0;
    m_mask   = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    exp_q.push_back(28'hFFFFFFF);
    w0 = n_wr;
    tick();
    chk("reinit_write", 32'(n_wr - w0), 32'd1);
    repeat (20) tick();
    chk("reinit_quiet", 32'(n_wr - w0), 32'd1);

    send_msg(3'd5);
    hold_and_restore(0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
